// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 target: FSM encoding, default command
// bytes and the field layout of the 32-bit cmd_addr word.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_ADDR,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ_DEF  = 8'h03;
    localparam logic [7:0] CMD_WRITE_DEF = 8'h02;

    localparam int CMD_MSB  = 31;
    localparam int CMD_LSB  = 24;
    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 0;

    localparam logic [5:0] FRAME_BITS = 6'd32;

    function automatic logic [7:0] cmd_of(input logic [31:0] cmd_addr);
        return cmd_addr[CMD_MSB:CMD_LSB];
    endfunction

    function automatic logic [23:0] addr_of(input logic [31:0] cmd_addr);
        return cmd_addr[ADDR_MSB:ADDR_LSB];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-clk
// rise/fall pulses derived from the synchronized level and its previous value.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Reset to 0 so a chip select held low across reset never fakes a cs_fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_target.sv
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) target: decodes a 32-bit cmd_addr
// header into a backend request, serves read data on MISO, collects write data.
module spi_slave_target
    import spi_pkg::*;
#(
    parameter logic [7:0] CMD_READ    = CMD_READ_DEF,
    parameter logic [7:0] CMD_WRITE   = CMD_WRITE_DEF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        req_valid,
    output logic        req_write,
    output logic [23:0] req_addr,
    input  logic        rd_valid,
    input  logic [31:0] rd_data,
    output logic        wr_valid,
    output logic [31:0] wr_data,
    output logic [5:0]  wr_bits,
    output logic        rd_underrun
);

    logic w_sck_level_unused, w_sck_rise, w_sck_fall;
    logic w_cs_level_unused, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .i_d(spi_clk),
        .o_level(w_sck_level_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_d(spi_cs_n),
        .o_level(w_cs_level_unused), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_d(spi_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    state_t      r_state;
    logic [5:0]  r_bit_cnt;
    logic [31:0] r_shift_in;
    logic [30:0] r_shift_out;   // bit 31 already lives on spi_miso
    logic [31:0] r_wr_shift;
    logic        r_loaded;
    logic        r_fell;
    logic        r_dphase;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_wr_shift  <= '0;
            r_loaded    <= 1'b0;
            r_fell      <= 1'b0;
            r_dphase    <= 1'b0;
            spi_miso    <= 1'b0;
            req_valid   <= 1'b0;
            req_write   <= 1'b0;
            req_addr    <= '0;
            wr_valid    <= 1'b0;
            wr_data     <= '0;
            wr_bits     <= '0;
            rd_underrun <= 1'b0;
        end else begin
            req_valid   <= 1'b0;
            wr_valid    <= 1'b0;
            rd_underrun <= 1'b0;
            if (r_state != ST_IDLE && w_cs_rise) begin
                r_state  <= ST_IDLE;
                spi_miso <= 1'b0;
                if (r_state == ST_WR_DATA && r_bit_cnt != 6'd0) begin
                    wr_valid <= 1'b1;
                    wr_data  <= r_wr_shift;
                    wr_bits  <= r_bit_cnt;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        spi_miso <= 1'b0;
                        if (w_cs_fall) begin
                            r_state    <= ST_CMD_ADDR;
                            r_bit_cnt  <= '0;
                            r_shift_in <= '0;
                        end
                    end
                    ST_CMD_ADDR: begin
                        if (r_bit_cnt == FRAME_BITS) begin
                            r_bit_cnt <= '0;
                            if (cmd_of(r_shift_in) == CMD_READ) begin
                                r_state     <= ST_RD_DATA;
                                req_valid   <= 1'b1;
                                req_write   <= 1'b0;
                                req_addr    <= addr_of(r_shift_in);
                                r_shift_out <= '0;
                                r_loaded    <= 1'b0;
                                r_fell      <= 1'b0;
                                r_dphase    <= 1'b0;
                            end else if (cmd_of(r_shift_in) == CMD_WRITE) begin
                                r_state    <= ST_WR_DATA;
                                req_valid  <= 1'b1;
                                req_write  <= 1'b1;
                                req_addr   <= addr_of(r_shift_in);
                                r_wr_shift <= '0;
                            end else begin
                                r_state <= ST_IGNORE;
                            end
                        end else if (w_sck_rise) begin
                            r_shift_in <= {r_shift_in[30:0], w_mosi};
                            r_bit_cnt  <= r_bit_cnt + 6'd1;
                        end
                    end
                    ST_RD_DATA: begin
                        // The trailing fall of the last header bit is not a data edge.
                        if (w_sck_rise)
                            r_dphase <= 1'b1;
                        if (w_sck_fall && r_dphase) begin
                            r_fell <= 1'b1;
                            if (r_loaded) begin
                                spi_miso    <= r_shift_out[30];
                                r_shift_out <= {r_shift_out[29:0], 1'b0};
                            end else if (!r_fell && rd_valid) begin
                                r_loaded    <= 1'b1;
                                spi_miso    <= rd_data[30];
                                r_shift_out <= {rd_data[29:0], 1'b0};
                            end else if (!r_fell) begin
                                rd_underrun <= 1'b1;
                            end
                        end else if (rd_valid && !r_loaded && !r_fell) begin
                            r_loaded    <= 1'b1;
                            spi_miso    <= rd_data[31];
                            r_shift_out <= rd_data[30:0];
                        end
                    end
                    ST_WR_DATA: begin
                        if (w_sck_rise) begin
                            r_wr_shift <= {r_wr_shift[30:0], w_mosi};
                            if (r_bit_cnt != FRAME_BITS)
                                r_bit_cnt <= r_bit_cnt + 6'd1;
                        end
                    end
                    default: begin
                        spi_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
